// File: rtl/tone_pkg.sv
// Shared types and constants for the tone decoder.
// Half-periods use the tone generator's notetime encoding.
package tone_pkg;

    localparam int NOTETIME_W = 15;

    // Silence code, shared with the note constants header.
    localparam logic [NOTETIME_W-1:0] NOTE_SILENT = '0;

    typedef enum logic [1:0] {
        SILENT  = 2'd0,
        ARMED   = 2'd1,
        ACQUIRE = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    // True when |a - b| <= tol; 16-bit signed math cannot overflow.
    function automatic logic within_tol(
        input logic [NOTETIME_W-1:0] a,
        input logic [NOTETIME_W-1:0] b,
        input logic [NOTETIME_W-1:0] tol
    );
        logic signed [NOTETIME_W:0] diff;
        logic        [NOTETIME_W:0] mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[NOTETIME_W] ? $unsigned(-diff) : $unsigned(diff);
        return mag <= {1'b0, tol};
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer and any-transition detector.
// edge_det is registered, arriving 3 clocks after a din change.
module tone_edge_sync (
    input  logic clk12MHz,
    input  logic rst,
    input  logic din,
    output logic edge_det
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic edge_q, edge_d;

    // Next values: shift the sample along and flag a change.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
        edge_d = s2_q ^ prev_q;
    end

    // Synchronizer, history and edge flops.
    always_ff @(posedge clk12MHz or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign edge_det = edge_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures the half-period of a square wave in 12 MHz cycles
// and reports it in notetime encoding once it is stable.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int                    TOL          = 4,
    parameter int                    STABLE_COUNT = 3,
    parameter logic [NOTETIME_W-1:0] TIMEOUT      = 15'h7FFF
) (
    input  logic                  clk12MHz,
    input  logic                  rst,
    input  logic                  tone_in,
    output logic [NOTETIME_W-1:0] notetime,
    output logic                  valid,
    output logic                  locked,
    output logic                  silent
);

    localparam logic [NOTETIME_W-1:0] TOL_V    = NOTETIME_W'(TOL);
    localparam logic [2:0]            STABLE_V = 3'(STABLE_COUNT);

    state_e                  state_q, state_d;
    logic [NOTETIME_W-1:0]   hcnt_q, hcnt_d;
    logic [NOTETIME_W-1:0]   cand_q, cand_d;
    logic [2:0]              match_q, match_d;
    logic [NOTETIME_W-1:0]   notetime_q, notetime_d;
    logic                    valid_q, valid_d;
    logic                    locked_q, locked_d;
    logic                    silent_q, silent_d;

    logic edge_det;
    logic timeout;
    logic near_cand;
    logic near_note;

    tone_edge_sync u_sync (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .din      (tone_in),
        .edge_det (edge_det)
    );

    // hcnt holds the measurement m when an edge arrives.
    assign timeout   = (hcnt_q == TIMEOUT);
    assign near_cand = within_tol(hcnt_q, cand_q, TOL_V);
    assign near_note = within_tol(hcnt_q, notetime_q, TOL_V);

    // Half-period counter: clear on edge, else count up to TIMEOUT.
    always_comb begin
        hcnt_d = hcnt_q;
        if (edge_det) begin
            hcnt_d = '0;
        end else if (!timeout) begin
            hcnt_d = hcnt_q + NOTETIME_W'(1);
        end
    end

    // Lock FSM: next state, candidate tracking and output values.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        match_d    = match_q;
        notetime_d = notetime_q;
        valid_d    = 1'b0;

        if (timeout && state_q != SILENT) begin
            // An edge on the timeout cycle measured nothing usable.
            state_d    = edge_det ? ARMED : SILENT;
            notetime_d = NOTE_SILENT;
            match_d    = '0;
        end else if (edge_det) begin
            unique case (state_q)
                SILENT: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    cand_d  = hcnt_q;
                    match_d = 3'd1;
                    if (STABLE_V == 3'd1) begin
                        state_d    = LOCKED;
                        notetime_d = hcnt_q;
                        valid_d    = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (near_cand) begin
                        match_d = match_q + 3'd1;
                        if (match_q + 3'd1 == STABLE_V) begin
                            state_d    = LOCKED;
                            notetime_d = hcnt_q;
                            valid_d    = 1'b1;
                        end
                    end else begin
                        cand_d  = hcnt_q;
                        match_d = 3'd1;
                    end
                end
                LOCKED: begin
                    // No jitter tracking: the locked value stays put.
                    if (!near_note) begin
                        state_d = ACQUIRE;
                        cand_d  = hcnt_q;
                        match_d = 3'd1;
                    end
                end
                default: begin
                    state_d = SILENT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
        silent_d = (state_d == SILENT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk12MHz or posedge rst) begin
        if (rst) begin
            state_q    <= SILENT;
            hcnt_q     <= '0;
            cand_q     <= '0;
            match_q    <= '0;
            notetime_q <= NOTE_SILENT;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            silent_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            notetime_q <= notetime_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            silent_q   <= silent_d;
        end
    end

    assign notetime = notetime_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign silent   = silent_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: drives square waves and checks against
// an edge-level model of the lock rules.
`timescale 1ns/1ps
module tb_tone_decoder;

    localparam int          TOL    = 4;
    localparam int          STABLE = 3;
    localparam int          TMO_I  = 4095;
    localparam logic [14:0] TMO    = 15'd4095;

    logic        clk = 1'b0;
    logic        rst;
    logic        tone_in;
    logic [14:0] notetime;
    logic        valid;
    logic        locked;
    logic        silent;

    tone_decoder #(
        .TOL          (TOL),
        .STABLE_COUNT (STABLE),
        .TIMEOUT      (TMO)
    ) dut (
        .clk12MHz (clk),
        .rst      (rst),
        .tone_in  (tone_in),
        .notetime (notetime),
        .valid    (valid),
        .locked   (locked),
        .silent   (silent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Pulse monitors sampled mid-cycle.
    int valid_cycles = 0;
    int valid_bad = 0;
    int silent_cycles = 0;
    bit lk_prev = 1'b0;
    always @(negedge clk) begin
        if (valid) valid_cycles <= valid_cycles + 1;
        if (valid && lk_prev) valid_bad <= valid_bad + 1;
        if (silent) silent_cycles <= silent_cycles + 1;
        lk_prev <= locked;
    end

    // Edge-level model state.
    int last_cyc = 0;
    int m_edges = 0;
    int m_run = 0;
    int m_anchor = 0;
    int m_note = 0;
    int exp_valid_total = 0;
    bit m_locked = 1'b0;
    bit exp_v = 1'b0;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_run = 0;
        m_anchor = 0;
        m_note = 0;
        m_locked = 1'b0;
        exp_v = 1'b0;
        last_cyc = cyc;
    endtask

    // Toggle the input and apply the spec rules to the new half-period.
    task automatic tog();
        int g;
        int m;
        g = cyc - last_cyc;
        last_cyc = cyc;
        tone_in = ~tone_in;
        exp_v = 1'b0;
        if (m_edges == 0 || g > TMO_I) begin
            m_edges = 1;
            m_run = 0;
            m_locked = 1'b0;
            m_note = 0;
        end else begin
            m = g - 1;
            m_edges++;
            if (m_locked) begin
                if (absd(m, m_note) > TOL) begin
                    m_locked = 1'b0;
                    m_anchor = m;
                    m_run = 1;
                end
            end else if (m_run == 0 || absd(m, m_anchor) > TOL) begin
                m_anchor = m;
                m_run = 1;
            end else begin
                m_run++;
                if (m_run == STABLE) begin
                    m_locked = 1'b1;
                    m_note = m;
                    exp_v = 1'b1;
                    exp_valid_total++;
                end
            end
        end
    endtask

    task automatic step(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({valid, locked, silent, notetime} !== {1'b0, 1'b0, 1'b1, 15'd0}) begin
            n_fail++;
            $display("FAIL reset_init: got v/l/s/nt=%b/%b/%b/%0d want 0/0/1/0",
                     valid, locked, silent, notetime);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            step(1137 - 4);
            tog();
            step(4);
            n_chk++;
            if ({valid, locked, silent, notetime} !==
                {exp_v, m_locked, 1'b0, m_note[14:0]}) begin
                n_fail++;
                $display("FAIL lock[%0d]: got v/l/s/nt=%b/%b/%b/%0d want %b/%b/0/%0d",
                         i, valid, locked, silent, notetime, exp_v, m_locked, m_note);
            end
        end
        n_chk++;
        if ({locked, silent, notetime} !== {1'b1, 1'b0, 15'd1136}) begin
            n_fail++;
            $display("FAIL lock_final: got l/s/nt=%b/%b/%0d want 1/0/1136",
                     locked, silent, notetime);
        end
    endtask

    task automatic test_jitter();
        int n;
        for (int i = 0; i < 11; i++) begin
            n = (i == 10) ? 1137 + 5 : 1137 + int'($urandom_range(0, 6)) - 3;
            step(n - 4);
            tog();
            step(4);
            n_chk++;
            if ({valid, locked, silent, notetime} !==
                {exp_v, m_locked, 1'b0, m_note[14:0]}) begin
                n_fail++;
                $display("FAIL jitter[%0d] hp=%0d: got v/l/s/nt=%b/%b/%b/%0d want %b/%b/0/%0d",
                         i, n, valid, locked, silent, notetime, exp_v, m_locked, m_note);
            end
        end
        n_chk++;
        if ({locked, notetime} !== {1'b0, 15'd1136}) begin
            n_fail++;
            $display("FAIL jitter_break: got l/nt=%b/%0d want 0/1136", locked, notetime);
        end
    endtask

    task automatic test_note_change();
        int n;
        for (int i = 0; i < 6; i++) begin
            n = (i < 3) ? 1137 : 902;
            step(n - 4);
            tog();
            step(4);
            n_chk++;
            if ({valid, locked, silent, notetime} !==
                {exp_v, m_locked, 1'b0, m_note[14:0]}) begin
                n_fail++;
                $display("FAIL note_change[%0d]: got v/l/s/nt=%b/%b/%b/%0d want %b/%b/0/%0d",
                         i, valid, locked, silent, notetime, exp_v, m_locked, m_note);
            end
        end
        n_chk++;
        if ({locked, notetime} !== {1'b1, 15'd901}) begin
            n_fail++;
            $display("FAIL note_change_final: got l/nt=%b/%0d want 1/901", locked, notetime);
        end
    endtask

    task automatic test_random();
        int base;
        int n;
        for (int g = 0; g < 8; g++) begin
            base = int'($urandom_range(8, 400));
            for (int i = 0; i < 5; i++) begin
                n = base + int'($urandom_range(0, 8)) - 4;
                step(n - 4);
                tog();
                step(4);
                n_chk++;
                if ({valid, locked, silent, notetime} !==
                    {exp_v, m_locked, 1'b0, m_note[14:0]}) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d] hp=%0d: got v/l/s/nt=%b/%b/%b/%0d want %b/%b/0/%0d",
                             g, i, n, valid, locked, silent, notetime, exp_v, m_locked, m_note);
                end
            end
        end
    endtask

    task automatic lock_301();
        for (int i = 0; i < 5; i++) begin
            step(301 - 4);
            tog();
            step(4);
        end
        n_chk++;
        if ({locked, notetime} !== {1'b1, 15'd300}) begin
            n_fail++;
            $display("FAIL relock_301: got l/nt=%b/%0d want 1/300", locked, notetime);
        end
    endtask

    task automatic test_silence();
        lock_301();
        // Edge seen 4 clocks after the toggle clears hcnt; TIMEOUT
        // clocks later hcnt saturates, one more clock goes silent.
        step(TMO_I);
        n_chk++;
        if ({locked, silent, notetime} !== {1'b1, 1'b0, 15'd300}) begin
            n_fail++;
            $display("FAIL silence_early: got l/s/nt=%b/%b/%0d want 1/0/300",
                     locked, silent, notetime);
        end
        step(1);
        n_chk++;
        if ({valid, locked, silent, notetime} !== {1'b0, 1'b0, 1'b1, 15'd0}) begin
            n_fail++;
            $display("FAIL silence: got v/l/s/nt=%b/%b/%b/%0d want 0/0/1/0",
                     valid, locked, silent, notetime);
        end
    endtask

    task automatic test_timeout_edge();
        int sc;
        lock_301();
        sc = silent_cycles;
        step(TMO_I + 1 - 4);
        tog();
        step(4);
        n_chk++;
        if ({valid, locked, silent} !== {1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_edge: got v/l/s=%b/%b/%b want 0/0/0",
                     valid, locked, silent);
        end
        n_chk++;
        if (silent_cycles !== sc) begin
            n_fail++;
            $display("FAIL timeout_edge_silent: got %0d silent cycles want 0",
                     silent_cycles - sc);
        end
        // From ARMED, three more edges are needed to lock.
        for (int i = 0; i < 3; i++) begin
            step(301 - 4);
            tog();
            step(4);
            n_chk++;
            if ({valid, locked, silent, notetime} !==
                {exp_v, m_locked, 1'b0, m_note[14:0]}) begin
                n_fail++;
                $display("FAIL armed_relock[%0d]: got v/l/s/nt=%b/%b/%b/%0d want %b/%b/0/%0d",
                         i, valid, locked, silent, notetime, exp_v, m_locked, m_note);
            end
        end
    endtask

    task automatic test_min_period();
        for (int i = 0; i < 6; i++) begin
            tog();
            step(2);
        end
        step(6);
        n_chk++;
        if ({locked, silent, notetime} !== {m_locked, 1'b0, m_note[14:0]}) begin
            n_fail++;
            $display("FAIL min_period_model: got l/s/nt=%b/%b/%0d want %b/0/%0d",
                     locked, silent, notetime, m_locked, m_note);
        end
        n_chk++;
        if ({locked, notetime} !== {1'b1, 15'd1}) begin
            n_fail++;
            $display("FAIL min_period: got l/nt=%b/%0d want 1/1", locked, notetime);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        n_chk++;
        if ({valid, locked, silent, notetime} !== {1'b0, 1'b0, 1'b1, 15'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got v/l/s/nt=%b/%b/%b/%0d want 0/0/1/0",
                     valid, locked, silent, notetime);
        end
        tone_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(301 - 4);
            tog();
            step(4);
            n_chk++;
            if ({valid, locked, silent, notetime} !==
                {exp_v, m_locked, 1'b0, m_note[14:0]}) begin
                n_fail++;
                $display("FAIL reset_relock[%0d]: got v/l/s/nt=%b/%b/%b/%0d want %b/%b/0/%0d",
                         i, valid, locked, silent, notetime, exp_v, m_locked, m_note);
            end
        end
        n_chk++;
        if ({locked, notetime} !== {1'b1, 15'd300}) begin
            n_fail++;
            $display("FAIL reset_relock_final: got l/nt=%b/%0d want 1/300",
                     locked, notetime);
        end
    endtask

    task automatic test_valid_pulses();
        step(2);
        n_chk++;
        if (valid_cycles !== exp_valid_total) begin
            n_fail++;
            $display("FAIL valid_count: got %0d valid cycles want %0d",
                     valid_cycles, exp_valid_total);
        end
        n_chk++;
        if (valid_bad !== 0) begin
            n_fail++;
            $display("FAIL valid_while_locked: got %0d want 0", valid_bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        tone_in = 1'b0;
        #1;
        test_reset();
        test_lock();
        test_jitter();
        test_note_change();
        test_random();
        test_silence();
        test_timeout_edge();
        test_min_period();
        test_reset_mid();
        test_valid_pulses();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
